// File: rtl/pe_seq_pkg.sv
// Shared constants and types for the PE instruction sequencer.
// Instruction layout: [31:30] op, [29:24] len, [23:16] waddr, [15:8] raddr1, [7:0] raddr0.
package pe_seq_pkg;

    localparam int unsigned INST_WIDTH    = 32;
    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned DM_ADDR_WIDTH = 8;
    localparam int unsigned IM_ADDR_WIDTH = 4;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 30;
    localparam int unsigned LEN_MSB   = 29;
    localparam int unsigned LEN_LSB   = 24;
    localparam int unsigned LEN_WIDTH = LEN_MSB - LEN_LSB + 1;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_READ = 2'b10,
        OP_HALT = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_LOAD,
        ST_READ,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pe_seq_inst_mem.sv
// Program memory: single write port, synchronous read port with a resettable output register.
module pe_seq_inst_mem #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Array is deliberately not reset so a loaded program survives rst.
    (* ram_style = "distributed" *) logic [WORD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pe_seq.sv
// Instruction sequencer feeding the PE data memory: replays a stored program of
// LOAD/READ bursts and aligns write data and read-valid to the memory's pipeline.
module pe_seq #(
    parameter int unsigned INST_WIDTH    = pe_seq_pkg::INST_WIDTH,
    parameter int unsigned DATA_WIDTH    = pe_seq_pkg::DATA_WIDTH,
    parameter int unsigned IM_ADDR_WIDTH = pe_seq_pkg::IM_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_v,
    input  logic [IM_ADDR_WIDTH-1:0] prog_addr,
    input  logic [INST_WIDTH-1:0]    prog_inst,
    input  logic                     start,
    input  logic [IM_ADDR_WIDTH:0]   n_inst,
    input  logic                     din_v,
    input  logic [DATA_WIDTH*2-1:0]  din,
    output logic                     din_rdy,
    output logic                     inst_v,
    output logic [INST_WIDTH-1:0]    inst,
    output logic                     wren,
    output logic                     rden,
    output logic [DATA_WIDTH*2-1:0]  dm_wdata,
    output logic                     dm_rvalid,
    output logic                     busy,
    output logic                     done
);
    import pe_seq_pkg::*;

    localparam int unsigned PC_WIDTH = IM_ADDR_WIDTH + 1;

    state_t                state_q, state_n;
    logic [PC_WIDTH-1:0]   pc_q, pc_n;
    logic [PC_WIDTH-1:0]   n_inst_q, n_inst_n;
    logic [LEN_WIDTH-1:0]  beat_q, beat_n;
    logic                  imem_we, imem_re;
    logic [INST_WIDTH-1:0] fetch_word;
    op_t                   cur_op;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic                  inst_v_n, din_rdy_n, rden_n, busy_n;
    logic                  rvalid_d1;

    pe_seq_inst_mem #(
        .ADDR_WIDTH (IM_ADDR_WIDTH),
        .WORD_WIDTH (INST_WIDTH)
    ) u_inst_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (imem_we),
        .waddr (prog_addr),
        .wdata (prog_inst),
        .re    (imem_re),
        .raddr (pc_q[IM_ADDR_WIDTH-1:0]),
        .rdata (fetch_word)
    );

    // Fetched word is held from ISSUE through the end of its burst.
    assign inst    = fetch_word;
    assign cur_op  = op_t'(fetch_word[OP_MSB:OP_LSB]);
    assign cur_len = fetch_word[LEN_MSB:LEN_LSB];
    assign wren    = din_rdy & din_v;

    // Next-state and registered-output decode.
    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        n_inst_n  = n_inst_q;
        beat_n    = beat_q;
        imem_we   = 1'b0;
        imem_re   = 1'b0;
        inst_v_n  = 1'b0;
        din_rdy_n = 1'b0;
        rden_n    = 1'b0;
        busy_n    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                imem_we = prog_v;
                if (start) begin
                    n_inst_n = n_inst;
                    pc_n     = '0;
                    state_n  = (n_inst == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_re = 1'b1;
                state_n = ST_ISSUE;
            end
            ST_ISSUE: begin
                beat_n = '0;
                case (cur_op)
                    OP_NOP:  state_n = ST_NEXT;
                    OP_LOAD: state_n = ST_LOAD;
                    OP_READ: state_n = ST_READ;
                    default: state_n = ST_DONE;
                endcase
            end
            ST_LOAD: begin
                if (din_v) begin
                    if (beat_q == cur_len) begin
                        state_n = ST_NEXT;
                    end else begin
                        beat_n = beat_q + LEN_WIDTH'(1);
                    end
                end
            end
            ST_READ: begin
                if (beat_q == cur_len) begin
                    state_n = ST_NEXT;
                end else begin
                    beat_n = beat_q + LEN_WIDTH'(1);
                end
            end
            // NEXT->FETCH->ISSUE keeps inst_v two cycles clear of the last strobe.
            ST_NEXT: begin
                pc_n    = pc_q + PC_WIDTH'(1);
                state_n = (pc_n == n_inst_q) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        inst_v_n  = (state_n == ST_ISSUE);
        din_rdy_n = (state_n == ST_LOAD);
        rden_n    = (state_n == ST_READ);
        busy_n    = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            n_inst_q  <= '0;
            beat_q    <= '0;
            inst_v    <= 1'b0;
            din_rdy   <= 1'b0;
            rden      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dm_wdata  <= '0;
            rvalid_d1 <= 1'b0;
            dm_rvalid <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            n_inst_q  <= n_inst_n;
            beat_q    <= beat_n;
            inst_v    <= inst_v_n;
            din_rdy   <= din_rdy_n;
            rden      <= rden_n;
            busy      <= busy_n;
            done      <= (state_q == ST_DONE);
            dm_wdata  <= din;
            rvalid_d1 <= rden;
            dm_rvalid <= rvalid_d1;
        end
    end

endmodule

// File: tb/tb_pe_seq.sv
// Bench for pe_seq: directed and random programs compared cycle-by-cycle against a
// timeline model built from the instruction list and the din_v pattern.
module tb_pe_seq;

    localparam int unsigned IW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int MAXC = 600;
    localparam logic [1:0] NOP = 2'b00, LD = 2'b01, RD = 2'b10, HLT = 2'b11;

    logic            clk = 1'b0;
    logic            rst;
    logic            prog_v;
    logic [AW-1:0]   prog_addr;
    logic [IW-1:0]   prog_inst;
    logic            start;
    logic [AW:0]     n_inst;
    logic            din_v;
    logic [2*DW-1:0] din;
    logic            din_rdy, inst_v, wren, rden, dm_rvalid, busy, done;
    logic [IW-1:0]   inst;
    logic [2*DW-1:0] dm_wdata;

    always #5 clk = ~clk;

    pe_seq #(.INST_WIDTH(IW), .DATA_WIDTH(DW), .IM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .prog_v(prog_v), .prog_addr(prog_addr), .prog_inst(prog_inst),
        .start(start), .n_inst(n_inst), .din_v(din_v), .din(din), .din_rdy(din_rdy),
        .inst_v(inst_v), .inst(inst), .wren(wren), .rden(rden), .dm_wdata(dm_wdata),
        .dm_rvalid(dm_rvalid), .busy(busy), .done(done)
    );

    logic [IW-1:0]   prog [16];
    bit              dv   [MAXC];
    logic [2*DW-1:0] dd   [MAXC];
    bit              st_x [MAXC];
    bit              pv_x [MAXC];
    bit e_iv [MAXC], e_wr [MAXC], e_rd [MAXC], e_rv [MAXC], e_dn [MAXC], e_bs [MAXC], e_rdy [MAXC];
    logic [IW-1:0]   e_inst [MAXC];
    int              e_end;
    int              obs_iv[$], obs_wr[$], obs_rd[$], obs_rv[$];
    int              n_checks = 0;
    int              n_fail = 0;

    function automatic logic [31:0] mk(input logic [1:0] op, input int len,
                                       input logic [7:0] wa, input logic [7:0] r1, input logic [7:0] r0);
        return {op, 6'(len), wa, r1, r0};
    endfunction

    // mode 0: din_v low, 1: din_v high, 2: random; din always random
    task automatic clear_stim(input int mode);
        for (int k = 0; k < MAXC; k++) begin
            dv[k]   = (mode == 1) || (mode == 2 && $urandom_range(0, 9) < 6) || (k >= 300);
            dd[k]   = $urandom;
            st_x[k] = 1'b0;
            pv_x[k] = 1'b0;
        end
    endtask

    task automatic write_prog(input int n);
        for (int i = 0; i < n; i++) begin
            prog_v = 1'b1; prog_addr = AW'(i); prog_inst = prog[i];
            @(posedge clk); #1;
        end
        prog_v = 1'b0;
    endtask

    // Timeline model: start at cycle 0, ISSUE at 2, 3 cycles of overhead between instructions.
    task automatic build_expect(input int n);
        int c, nxt, k, beats, len, idx, dstate;
        bit fin;
        logic [1:0] op;
        for (int i = 0; i < MAXC; i++) begin
            e_iv[i] = 0; e_wr[i] = 0; e_rd[i] = 0; e_rv[i] = 0;
            e_dn[i] = 0; e_bs[i] = 0; e_rdy[i] = 0; e_inst[i] = '0;
        end
        dstate = 1;
        fin = (n == 0);
        c = 2; idx = 0; nxt = 0;
        while (!fin) begin
            e_iv[c] = 1; e_inst[c] = prog[idx];
            op  = prog[idx][31:30];
            len = int'(prog[idx][29:24]);
            if (op == HLT) begin
                dstate = c + 1; fin = 1;
            end else begin
                if (op == LD) begin
                    k = c + 1; beats = 0;
                    while (beats < len + 1) begin
                        e_rdy[k] = 1;
                        if (dv[k]) begin e_wr[k] = 1; beats++; end
                        k++;
                    end
                    nxt = k;
                end else if (op == RD) begin
                    for (int j = 1; j <= len + 1; j++) begin
                        e_rd[c+j] = 1; e_rv[c+j+2] = 1;
                    end
                    nxt = c + len + 2;
                end else begin
                    nxt = c + 1;
                end
                idx++;
                if (idx == n) begin dstate = nxt + 1; fin = 1; end
                else c = nxt + 2;
            end
        end
        for (int i = 1; i <= dstate; i++) e_bs[i] = 1;
        e_dn[dstate+1] = 1;
        e_end = dstate + 2;
    endtask

    task automatic run_check(input int n, input string tag);
        logic [6:0] ob, ex;
        build_expect(n);
        obs_iv.delete(); obs_wr.delete(); obs_rd.delete(); obs_rv.delete();
        n_inst = (AW+1)'(n);
        for (int k = 0; k <= e_end; k++) begin
            start = (k == 0) || st_x[k];
            prog_v = pv_x[k]; prog_addr = '0; prog_inst = ~prog[0];
            din_v = dv[k]; din = dd[k];
            @(negedge clk);
            ob = {inst_v, wren, rden, dm_rvalid, done, busy, din_rdy};
            ex = {e_iv[k], e_wr[k], e_rd[k], e_rv[k], e_dn[k], e_bs[k], e_rdy[k]};
            n_checks++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL %s ctrl cycle %0d: got %b expected %b (iv,wr,rd,rv,dn,bs,rdy)", tag, k, ob, ex);
            end
            if (e_iv[k]) begin
                n_checks++;
                if (inst !== e_inst[k]) begin
                    n_fail++;
                    $display("FAIL %s inst cycle %0d: got %h expected %h", tag, k, inst, e_inst[k]);
                end
            end
            if (k > 0) begin
                n_checks++;
                if (dm_wdata !== dd[k-1]) begin
                    n_fail++;
                    $display("FAIL %s dm_wdata cycle %0d: got %h expected %h", tag, k, dm_wdata, dd[k-1]);
                end
            end
            if (inst_v)    obs_iv.push_back(k);
            if (wren)      obs_wr.push_back(k);
            if (rden)      obs_rd.push_back(k);
            if (dm_rvalid) obs_rv.push_back(k);
            @(posedge clk); #1;
        end
        start = 1'b0; prog_v = 1'b0; din_v = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({din_rdy, inst_v, inst, wren, rden, dm_wdata, dm_rvalid, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got rdy=%b iv=%b inst=%h wr=%b rd=%b wd=%h rv=%b busy=%b done=%b expected all 0",
                     din_rdy, inst_v, inst, wren, rden, dm_wdata, dm_rvalid, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_load_burst;
        prog[0] = mk(LD, 3, 8'h10, 8'h00, 8'h00);
        prog[1] = mk(HLT, 0, 8'h00, 8'h00, 8'h00);
        write_prog(2);
        clear_stim(1);
        for (int i = 0; i < 4; i++) dd[3+i] = 32'hA0 + 32'(i);
        run_check(2, "load_burst");
        n_checks++;
        if (obs_wr.size() != 4 || obs_wr[0] != 3) begin
            n_fail++;
            $display("FAIL load_burst wren: got %0d pulses first at %0d expected 4 first at 3", obs_wr.size(), obs_wr[0]);
        end
        n_checks++;
        if (obs_iv.size() != 2 || obs_iv[0] != 2) begin
            n_fail++;
            $display("FAIL load_burst inst_v: got %0d pulses first at %0d expected 2 first at 2", obs_iv.size(), obs_iv[0]);
        end
    endtask

    task automatic test_stalled_load;
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        clear_stim(0);
        for (int i = 0; i < 7; i++) dv[3+i] = pat[i];
        run_check(2, "stalled_load");
        n_checks++;
        if (obs_wr.size() != 4 || obs_wr[3] != 9) begin
            n_fail++;
            $display("FAIL stalled_load wren: got %0d pulses last at %0d expected 4 last at 9", obs_wr.size(), obs_wr[3]);
        end
    endtask

    task automatic test_read;
        prog[0] = mk(RD, 1, 8'h00, 8'h11, 8'h10);
        prog[1] = mk(HLT, 0, 8'h00, 8'h00, 8'h00);
        write_prog(2);
        clear_stim(2);
        run_check(2, "read");
        n_checks++;
        if (obs_rd.size() != 2 || obs_rd[0] != 3 || obs_rv.size() != 2 || obs_rv[0] != 5) begin
            n_fail++;
            $display("FAIL read timing: got rden %0d@%0d rvalid %0d@%0d expected 2@3 and 2@5",
                     obs_rd.size(), obs_rd[0], obs_rv.size(), obs_rv[0]);
        end
    endtask

    task automatic test_back_to_back;
        prog[0] = mk(LD, 0, 8'h05, 8'h00, 8'h00);
        prog[1] = mk(LD, 0, 8'h09, 8'h00, 8'h00);
        write_prog(2);
        clear_stim(1);
        run_check(2, "back_to_back");
        n_checks++;
        if (obs_iv.size() != 2 || obs_wr.size() != 2 || obs_iv[1] - obs_wr[0] != 3) begin
            n_fail++;
            $display("FAIL back_to_back gap: got iv=%0d wr=%0d gap %0d expected 2,2 gap 3",
                     obs_iv.size(), obs_wr.size(), obs_iv[1] - obs_wr[0]);
        end
    endtask

    task automatic test_n_inst_zero;
        clear_stim(2);
        run_check(0, "n_inst_zero");
        n_checks++;
        if (obs_iv.size() + obs_wr.size() + obs_rd.size() != 0) begin
            n_fail++;
            $display("FAIL n_inst_zero strobes: got %0d expected 0", obs_iv.size() + obs_wr.size() + obs_rd.size());
        end
    endtask

    task automatic test_busy_ignore;
        prog[0] = mk(LD, 1, 8'h20, 8'h00, 8'h00);
        prog[1] = mk(HLT, 0, 8'h00, 8'h00, 8'h00);
        write_prog(2);
        clear_stim(0);
        dv[7] = 1; dv[8] = 1;
        st_x[4] = 1; pv_x[4] = 1; st_x[5] = 1; pv_x[6] = 1;
        run_check(2, "busy_ignore");
        clear_stim(1);
        run_check(2, "after_ignore");
    endtask

    task automatic test_reset_mid_burst;
        prog[0] = mk(LD, 3, 8'h10, 8'h00, 8'h00);
        prog[1] = mk(HLT, 0, 8'h00, 8'h00, 8'h00);
        write_prog(2);
        start = 1'b1; n_inst = 5'd2; din_v = 1'b1; din = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wren !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_burst second beat wren: got %b expected 1", wren);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({din_rdy, inst_v, inst, wren, rden, dm_wdata, dm_rvalid, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL mid_burst reset outputs: got rdy=%b iv=%b inst=%h wr=%b rd=%b wd=%h rv=%b busy=%b done=%b expected all 0",
                     din_rdy, inst_v, inst, wren, rden, dm_wdata, dm_rvalid, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0; din_v = 1'b0;
        clear_stim(1);
        run_check(2, "replay");
    endtask

    task automatic test_full_program;
        for (int i = 0; i < 16; i++)
            prog[i] = mk((i % 2 == 0) ? NOP : RD, 0, 8'(i), 8'(i + 1), 8'(i + 2));
        write_prog(16);
        clear_stim(2);
        run_check(16, "full_prog");
    endtask

    task automatic test_random;
        int n, p;
        logic [1:0] op;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                p  = $urandom_range(0, 9);
                op = (p < 3) ? LD : (p < 6) ? RD : (p < 9) ? NOP : HLT;
                prog[i] = mk(op, $urandom_range(0, 7), 8'($urandom), 8'($urandom), 8'($urandom));
            end
            write_prog(n);
            clear_stim(2);
            run_check(n, "random");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; start = 1'b0; prog_v = 1'b0; prog_addr = '0; prog_inst = '0;
        n_inst = '0; din_v = 1'b0; din = '0;
        test_reset;
        test_load_burst;
        test_stalled_load;
        test_read;
        test_back_to_back;
        test_n_inst_zero;
        test_busy_ignore;
        test_reset_mid_burst;
        test_full_program;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
